// File: rtl/conv2d_line_scheduler_if.sv
// Bus bundle between the conv2d line scheduler and its environment.
// master: scheduler side. slave: fetch/engine/control side.
interface conv2d_line_scheduler_if #(
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 16
);

  logic                 i_start;
  logic                 i_abort;
  logic [CNT_WIDTH-1:0] i_conf_row_len;
  logic [CNT_WIDTH-1:0] i_conf_num_rows;
  logic                 o_weight_req;
  logic                 i_weight_val;
  logic                 o_data_req;
  logic                 i_data_val;
  logic                 i_buf_full;
  logic                 i_psum_val;
  logic                 o_engine_enb;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_err;
  logic [CNT_WIDTH-1:0] o_row_cnt;
  logic [CNT_WIDTH-1:0] o_col_cnt;
  logic [REG_WIDTH-1:0] o_stall_cnt;

  modport master (
    input  i_start, i_abort, i_conf_row_len, i_conf_num_rows,
    input  i_weight_val, i_data_val, i_buf_full, i_psum_val,
    output o_weight_req, o_data_req, o_engine_enb, o_busy, o_done, o_err,
    output o_row_cnt, o_col_cnt, o_stall_cnt
  );

  modport slave (
    output i_start, i_abort, i_conf_row_len, i_conf_num_rows,
    output i_weight_val, i_data_val, i_buf_full, i_psum_val,
    input  o_weight_req, o_data_req, o_engine_enb, o_busy, o_done, o_err,
    input  o_row_cnt, o_col_cnt, o_stall_cnt
  );

endinterface

// File: rtl/conv2d_line_scheduler.sv
// Line scheduler for a 2D convolution engine: loads a kernel set, then
// streams activations line by line and waits for each line's psums.
// Optional stall counter enabled by macro CONV2D_SCHED_STALL_CNT_EN.
module conv2d_line_scheduler #(
  parameter int unsigned REG_WIDTH    = 32,
  parameter int unsigned WEIGHT_BEATS = 3,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input logic                     clk,
  input logic                     rst,
  conv2d_line_scheduler_if.master bus
);

  localparam int unsigned WB_W = $clog2(WEIGHT_BEATS + 1);
  localparam logic [WB_W-1:0] WB_LAST = WB_W'(WEIGHT_BEATS - 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, RUN, DRAIN, DONE} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] row_len_q, row_len_d;
  logic [CNT_WIDTH-1:0] num_rows_q, num_rows_d;
  logic [CNT_WIDTH-1:0] col_q, col_d;
  logic [CNT_WIDTH-1:0] psum_q, psum_d;
  logic [CNT_WIDTH-1:0] row_q, row_d;
  logic [WB_W-1:0]      wcnt_q, wcnt_d;
  logic                 weight_req_q, weight_req_d;
  logic                 data_req_q, data_req_d;
  logic                 engine_enb_q, engine_enb_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 streaming_c;

`ifdef CONV2D_SCHED_STALL_CNT_EN
  logic [REG_WIDTH-1:0] stall_q, stall_d;
`endif

  // Next state, counter updates and next registered outputs.
  always_comb begin
    state_d     = state_q;
    row_len_d   = row_len_q;
    num_rows_d  = num_rows_q;
    col_d       = col_q;
    psum_d      = psum_q;
    row_d       = row_q;
    wcnt_d      = wcnt_q;
    err_d       = 1'b0;
    streaming_c = (state_q == RUN) || (state_q == DRAIN);
`ifdef CONV2D_SCHED_STALL_CNT_EN
    stall_d = stall_q;
    if ((state_q == RUN) && (bus.i_buf_full || (data_req_q && !bus.i_data_val)) &&
        (stall_q != {REG_WIDTH{1'b1}})) begin
      stall_d = stall_q + REG_WIDTH'(1);
    end
    if ((state_q == IDLE) && bus.i_start) begin
      stall_d = '0;
    end
`endif

    // Activation beats beyond the line length are flagged, not counted.
    if (streaming_c && bus.i_data_val) begin
      if (col_q < row_len_q) begin
        col_d = col_q + CNT_WIDTH'(1);
      end else begin
        err_d = 1'b1;
      end
    end

    // Psums only count while a line is in flight and never past row_len.
    if (bus.i_psum_val) begin
      if (streaming_c && (psum_q < row_len_q)) begin
        psum_d = psum_q + CNT_WIDTH'(1);
      end else if (state_q != DONE) begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          if ((bus.i_conf_row_len != '0) && (bus.i_conf_num_rows != '0)) begin
            row_len_d  = bus.i_conf_row_len;
            num_rows_d = bus.i_conf_num_rows;
            col_d      = '0;
            psum_d     = '0;
            row_d      = '0;
            wcnt_d     = '0;
            state_d    = LOAD_W;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD_W: begin
        if (bus.i_weight_val) begin
          wcnt_d = wcnt_q + WB_W'(1);
          if (wcnt_q == WB_LAST) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (col_d == row_len_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (psum_q == row_len_q) begin
          col_d  = '0;
          psum_d = '0;
          if (row_q == (num_rows_q - CNT_WIDTH'(1))) begin
            state_d = DONE;
          end else begin
            row_d   = row_q + CNT_WIDTH'(1);
            state_d = RUN;
          end
        end
      end
      DONE: begin
        row_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides every transition above.
    if (bus.i_abort) begin
      state_d = IDLE;
      col_d   = '0;
      psum_d  = '0;
      row_d   = '0;
      wcnt_d  = '0;
      err_d   = 1'b0;
`ifdef CONV2D_SCHED_STALL_CNT_EN
      stall_d = '0;
`endif
    end

    weight_req_d = (state_d == LOAD_W);
    data_req_d   = (state_d == RUN) && !bus.i_buf_full && (col_d < row_len_q);
    engine_enb_d = (state_d == RUN);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      row_len_q    <= '0;
      num_rows_q   <= '0;
      col_q        <= '0;
      psum_q       <= '0;
      row_q        <= '0;
      wcnt_q       <= '0;
      weight_req_q <= 1'b0;
      data_req_q   <= 1'b0;
      engine_enb_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_len_q    <= row_len_d;
      num_rows_q   <= num_rows_d;
      col_q        <= col_d;
      psum_q       <= psum_d;
      row_q        <= row_d;
      wcnt_q       <= wcnt_d;
      weight_req_q <= weight_req_d;
      data_req_q   <= data_req_d;
      engine_enb_q <= engine_enb_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

`ifdef CONV2D_SCHED_STALL_CNT_EN
  // Saturating stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign bus.o_stall_cnt = stall_q;
`else
  assign bus.o_stall_cnt = REG_WIDTH'(0);
`endif

  assign bus.o_weight_req = weight_req_q;
  assign bus.o_data_req   = data_req_q;
  assign bus.o_engine_enb = engine_enb_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_err        = err_q;
  assign bus.o_row_cnt    = row_q;
  assign bus.o_col_cnt    = col_q;

endmodule

// File: tb/tb_conv2d_line_scheduler.sv
// Self-checking bench for conv2d_line_scheduler.
module tb_conv2d_line_scheduler;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned REG_W = 32;
  localparam int unsigned WB    = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_checks;
  int   n_errors;

  conv2d_line_scheduler_if #(.REG_WIDTH(REG_W), .CNT_WIDTH(CNT_W)) bus ();

  conv2d_line_scheduler #(
    .REG_WIDTH(REG_W),
    .WEIGHT_BEATS(WB),
    .CNT_WIDTH(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rl;
    int nr;
    int exp_err;
    int exp_busy;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_start      = 1'b0;
    bus.i_abort      = 1'b0;
    bus.i_weight_val = 1'b0;
    bus.i_data_val   = 1'b0;
    bus.i_buf_full   = 1'b0;
    bus.i_psum_val   = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.i_abort = 1'b1;
    @(negedge clk);
    bus.i_abort = 1'b0;
  endtask

  // Start a layer and supply weights promptly until the engine is enabled.
  task automatic start_layer(input int rl, input int nr, output int wbeats);
    bus.i_conf_row_len  = CNT_W'(rl);
    bus.i_conf_num_rows = CNT_W'(nr);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    wbeats = 0;
    for (int c = 0; c < 100 && !bus.o_engine_enb; c++) begin
      bus.i_weight_val = bus.o_weight_req;
      if (bus.i_weight_val) wbeats++;
      @(negedge clk);
    end
    bus.i_weight_val = 1'b0;
    check("enter_run", int'(bus.o_engine_enb), 1);
  endtask

  task automatic send_data(input int n);
    for (int k = 0; k < n; k++) begin
      int c;
      c = 0;
      while (!bus.o_data_req && c < 100) begin
        @(negedge clk);
        c++;
      end
      check("data_req_wait", int'(bus.o_data_req), 1);
      bus.i_data_val = 1'b1;
      @(negedge clk);
      bus.i_data_val = 1'b0;
    end
  endtask

  task automatic send_psum(input int n);
    for (int k = 0; k < n; k++) begin
      bus.i_psum_val = 1'b1;
      @(negedge clk);
    end
    bus.i_psum_val = 1'b0;
  endtask

  // Whole layer under a randomized environment; expectations come from beat arithmetic.
  task automatic run_layer(input int rl, input int nr, input int p_data,
                           input int p_psum, input int p_full);
    int w_sent, d_sent, p_sent, dones, errs;
    bit last_data, finished;
    w_sent = 0; d_sent = 0; p_sent = 0; dones = 0; errs = 0;
    last_data = 1'b0; finished = 1'b0;
    bus.i_conf_row_len  = CNT_W'(rl);
    bus.i_conf_num_rows = CNT_W'(nr);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      if (bus.o_done) dones++;
      if (bus.o_err) errs++;
      if (last_data) begin
        check("beat_col", int'(bus.o_col_cnt), ((d_sent - 1) % rl) + 1);
        check("beat_row", int'(bus.o_row_cnt), (d_sent - 1) / rl);
      end
      last_data = 1'b0;
      if (dones > 0 && !bus.o_busy) begin
        finished = 1'b1;
      end else begin
        bus.i_weight_val = bus.o_weight_req && (int'($urandom_range(0, 99)) < p_data);
        bus.i_psum_val   = (d_sent > p_sent) && (int'($urandom_range(0, 99)) < p_psum);
        bus.i_data_val   = bus.o_data_req && (int'($urandom_range(0, 99)) < p_data);
        bus.i_buf_full   = (int'($urandom_range(0, 99)) < p_full);
        if (bus.i_weight_val) w_sent++;
        if (bus.i_psum_val) p_sent++;
        if (bus.i_data_val) begin
          d_sent++;
          last_data = 1'b1;
        end
        @(negedge clk);
      end
    end
    idle_inputs();
    check("layer_finished", int'(finished), 1);
    check("layer_weights", w_sent, int'(WB));
    check("layer_data", d_sent, rl * nr);
    check("layer_psums", p_sent, rl * nr);
    check("layer_dones", dones, 1);
    check("layer_errs", errs, 0);
    check("layer_row_clr", int'(bus.o_row_cnt), 0);
  endtask

  initial begin
    int wb;
    int dones;
    n_checks = 0;
    n_errors = 0;
    vecs[0] = '{0, 2, 1, 0};
    vecs[1] = '{4, 0, 1, 0};
    vecs[2] = '{0, 0, 1, 0};
    vecs[3] = '{3, 2, 0, 1};
    vecs[4] = '{1, 1, 0, 1};
    vecs[5] = '{65535, 1, 0, 1};

    rst = 1'b1;
    idle_inputs();
    bus.i_conf_row_len  = '0;
    bus.i_conf_num_rows = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(bus.o_busy), 0);
    check("rst_done", int'(bus.o_done), 0);
    check("rst_err", int'(bus.o_err), 0);
    check("rst_wreq", int'(bus.o_weight_req), 0);
    check("rst_dreq", int'(bus.o_data_req), 0);
    check("rst_eng", int'(bus.o_engine_enb), 0);
    check("rst_row", int'(bus.o_row_cnt), 0);
    check("rst_col", int'(bus.o_col_cnt), 0);
    check("rst_stall", int'(bus.o_stall_cnt), 0);
    rst = 1'b0;
    @(negedge clk);

    // Start acceptance table; the follow-up zero-conf start errors only from IDLE.
    for (int i = 0; i < 6; i++) begin
      bus.i_conf_row_len  = CNT_W'(vecs[i].rl);
      bus.i_conf_num_rows = CNT_W'(vecs[i].nr);
      bus.i_start = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_err", i), int'(bus.o_err), vecs[i].exp_err);
      check($sformatf("vec%0d_busy", i), int'(bus.o_busy), vecs[i].exp_busy);
      bus.i_conf_row_len  = '0;
      bus.i_conf_num_rows = '0;
      @(negedge clk);
      bus.i_start = 1'b0;
      check($sformatf("vec%0d_restart_err", i), int'(bus.o_err), 1 - vecs[i].exp_busy);
      check($sformatf("vec%0d_restart_busy", i), int'(bus.o_busy), vecs[i].exp_busy);
      pulse_abort();
      check($sformatf("vec%0d_abort_busy", i), int'(bus.o_busy), 0);
    end

    // Nominal layer with prompt responses.
    run_layer(4, 2, 100, 100, 0);

    // Backpressure: buf_full held for five cycles in RUN.
    start_layer(8, 1, wb);
    check("bp_wbeats", wb, int'(WB));
    check("bp_req_before", int'(bus.o_data_req), 1);
    bus.i_buf_full = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_req_low%0d", k), int'(bus.o_data_req), 0);
    end
    bus.i_buf_full = 1'b0;
    @(negedge clk);
    check("bp_req_after", int'(bus.o_data_req), 1);
`ifdef CONV2D_SCHED_STALL_CNT_EN
    check("bp_stall_min", int'(bus.o_stall_cnt >= REG_W'(5)), 1);
`else
    check("bp_stall_tied", int'(bus.o_stall_cnt), 0);
`endif
    pulse_abort();
    check("bp_stall_clr", int'(bus.o_stall_cnt), 0);
    check("bp_abort_busy", int'(bus.o_busy), 0);

    // Abort while draining row 1 of 3.
    start_layer(2, 3, wb);
    send_data(2);
    send_psum(2);
    send_data(2);
    check("ab_row", int'(bus.o_row_cnt), 1);
    check("ab_col", int'(bus.o_col_cnt), 2);
    check("ab_drain", int'(bus.o_busy && !bus.o_engine_enb), 1);
    pulse_abort();
    check("ab_busy", int'(bus.o_busy), 0);
    check("ab_row_clr", int'(bus.o_row_cnt), 0);
    check("ab_col_clr", int'(bus.o_col_cnt), 0);
    check("ab_dreq", int'(bus.o_data_req), 0);
    check("ab_wreq", int'(bus.o_weight_req), 0);
    dones = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.o_done) dones++;
      @(negedge clk);
    end
    check("ab_no_done", dones, 0);

    // Protocol errors: excess data beat, then a psum in IDLE.
    start_layer(4, 1, wb);
    send_data(4);
    bus.i_data_val = 1'b1;
    @(negedge clk);
    bus.i_data_val = 1'b0;
    check("err_data_pulse", int'(bus.o_err), 1);
    check("err_data_col", int'(bus.o_col_cnt), 4);
    @(negedge clk);
    check("err_data_clear", int'(bus.o_err), 0);
    pulse_abort();
    bus.i_psum_val = 1'b1;
    @(negedge clk);
    bus.i_psum_val = 1'b0;
    check("err_psum_idle", int'(bus.o_err), 1);
    check("err_psum_busy", int'(bus.o_busy), 0);

    // Asynchronous reset between edges while in RUN.
    start_layer(3, 2, wb);
    send_data(1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", int'(bus.o_busy), 0);
    check("arst_eng", int'(bus.o_engine_enb), 0);
    check("arst_dreq", int'(bus.o_data_req), 0);
    check("arst_col", int'(bus.o_col_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("arst_stays_idle", int'(bus.o_busy), 0);

    // Randomized layers.
    for (int t = 0; t < 8; t++) begin
      run_layer(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)),
                int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                int'($urandom_range(0, 60)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
